// File: rtl/rx_pkg.sv
// Shared port definitions for the five-port receive arbiter.
// Latency and backpressure: none, types and helpers only.
package rx_pkg;

  localparam int NUM_PORTS = 5;

  typedef logic [2:0] port_idx_t;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_E = 3'd1,
    PORT_S = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_name_t;

  // Cyclic successor: the last port wraps back to the first.
  function automatic port_idx_t next_port(input port_idx_t p);
    return (p == port_idx_t'(PORT_L)) ? port_idx_t'(PORT_N) : port_idx_t'(p + 3'd1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational cyclic search for the first pending port at or after ptr.
// Zero latency, no state, no backpressure.
module rr_pick
  import rx_pkg::*;
(
  input  logic [NUM_PORTS-1:0] pending,
  input  logic [2:0]           ptr,
  output logic                 any,
  output logic [2:0]           idx
);

  int        cand;
  port_idx_t cidx;

  // Walk from the farthest candidate back toward ptr so the nearest hit wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = 0;
    cidx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      cidx = port_idx_t'(cand);
      if (pending[cidx]) begin
        any = 1'b1;
        idx = cidx;
      end
    end
  end

endmodule

// File: rtl/rx_rr_arbiter.sv
// Round-robin merge of five two-phase senders into one FIFO write port; 1 cycle req-to-write,
// 3 with RX_ARB_SYNC_EN (2-flop req synchronizer); fifo_full holds every grant, nothing is dropped.
module rx_rr_arbiter
  import rx_pkg::*;
#(
  parameter int SIZE     = 8,
  parameter int PTR_INIT = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_PORTS-1:0]      fifo_push_req,
  output logic [NUM_PORTS-1:0]      fifo_push_ack,
  input  logic [NUM_PORTS*SIZE-1:0] fifo_push_data,
  input  logic                      fifo_full,
  output logic                      fifo_write,
  output logic [SIZE-1:0]           fifo_data_in,
  output logic [2:0]                grant_idx
);

  logic [NUM_PORTS-1:0] req_s;
  logic [NUM_PORTS-1:0] pending;
  port_idx_t            ptr;
  logic                 pick_any;
  port_idx_t            pick_idx;
  logic [SIZE-1:0]      pick_data;

`ifdef RX_ARB_SYNC_EN
  logic [NUM_PORTS-1:0] sync_q1;
  logic [NUM_PORTS-1:0] sync_q2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= fifo_push_req;
      sync_q2 <= sync_q1;
    end
  end

  assign req_s = sync_q2;
`else
  assign req_s = fifo_push_req;
`endif

  // A sender has an item outstanding whenever its request and our ack levels differ.
  assign pending = req_s ^ fifo_push_ack;

  rr_pick u_pick (
    .pending (pending),
    .ptr     (ptr),
    .any     (pick_any),
    .idx     (pick_idx)
  );

  always_comb begin
    pick_data = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (pick_idx == port_idx_t'(k)) pick_data = fifo_push_data[SIZE*k +: SIZE];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_push_ack <= '0;
      fifo_write    <= 1'b0;
      fifo_data_in  <= '0;
      grant_idx     <= '0;
      ptr           <= port_idx_t'(PTR_INIT);
    end else if (pick_any && !fifo_full) begin
      fifo_write    <= 1'b1;
      fifo_data_in  <= pick_data;
      grant_idx     <= pick_idx;
      fifo_push_ack <= fifo_push_ack ^ (NUM_PORTS'(1) << pick_idx);
      ptr           <= next_port(pick_idx);
    end else begin
      fifo_write    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_rr_arbiter.sv
// Directed and randomized checks of rx_rr_arbiter against a cycle-level behavioural model.
module tb_rx_rr_arbiter;

  localparam int SIZE     = 8;
  localparam int N        = 5;
  localparam int PTR_INIT = 0;
`ifdef RX_ARB_SYNC_EN
  localparam bit SYNC = 1'b1;
  localparam int LAT  = 3;
`else
  localparam bit SYNC = 1'b0;
  localparam int LAT  = 1;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [N-1:0]      ack;
  logic [N*SIZE-1:0] pdata;
  logic              full;
  logic              write;
  logic [SIZE-1:0]   din;
  logic [2:0]        gidx;

  always #5 clk = ~clk;

  rx_rr_arbiter #(.SIZE(SIZE), .PTR_INIT(PTR_INIT)) dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_push_req  (req),
    .fifo_push_ack  (ack),
    .fifo_push_data (pdata),
    .fifo_full      (full),
    .fifo_write     (write),
    .fifo_data_in   (din),
    .grant_idx      (gidx)
  );

  // Behavioural model state
  logic [SIZE-1:0] dat [N];
  bit              m_ack [N];
  int              m_ptr;
  bit              m_write;
  int              m_data;
  int              m_gidx;
  logic [N-1:0]    dly [2];

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pack_data();
    for (int k = 0; k < N; k++) pdata[SIZE*k +: SIZE] = dat[k];
  endtask

  task automatic toggle(input int k, input logic [SIZE-1:0] d);
    dat[k] = d;
    req[k] = ~req[k];
    pack_data();
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_ack[k] = 1'b0;
    m_ptr = PTR_INIT; m_write = 1'b0; m_data = 0; m_gidx = 0;
    dly[0] = '0; dly[1] = '0;
  endtask

  // One clock edge of the arbiter rules: first outstanding sender from ptr, cyclically.
  task automatic predict();
    logic [N-1:0] rs;
    int g;
    int c;
    rs = SYNC ? dly[1] : req;
    g  = -1;
    if (!full) begin
      for (int i = 0; i < N; i++) begin
        c = (m_ptr + i) % N;
        if (g < 0 && rs[c] != m_ack[c]) g = c;
      end
    end
    if (g >= 0) begin
      m_write  = 1'b1;
      m_data   = int'(dat[g]);
      m_gidx   = g;
      m_ack[g] = ~m_ack[g];
      m_ptr    = (g + 1) % N;
    end else begin
      m_write = 1'b0;
    end
    dly[1] = dly[0];
    dly[0] = req;
  endtask

  task automatic compare_all();
    logic [N-1:0] ea;
    for (int k = 0; k < N; k++) ea[k] = m_ack[k];
    chk("write", 32'(write), 32'(m_write));
    chk("grant_idx", 32'(gidx), m_gidx);
    chk("data", 32'(din), m_data);
    chk("ack", 32'(ack), 32'(ea));
  endtask

  task automatic cycle();
    predict();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  initial begin #200000; $display("FAIL watchdog timeout"); $fatal(1, "timeout"); end

  initial begin
    int seq_a [5];
    int seq_b [5];
    int prev;
    bit have_prev;
    int w0, max_w;
    int lat;
    bit seen;

    seq_a = '{3, 4, 0, 1, 2};
    seq_b = '{0, 1, 2, 3, 4};
    reset = 1'b0; req = '0; full = 1'b0;
    for (int k = 0; k < N; k++) dat[k] = '0;
    pack_data();
    model_reset();

    #12;
    chk("rst_write", 32'(write), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_data", 32'(din), 0);
    chk("rst_gidx", 32'(gidx), 0);
    @(negedge clk);
    reset = 1'b1;
    cycle();

    // Single sender 2
    toggle(2, 8'hA5);
    repeat (LAT) cycle();
    chk("single_write", 32'(write), 1);
    chk("single_gidx", 32'(gidx), 2);
    chk("single_ack2", 32'(ack[2]), 1);
    chk("single_data", 32'(din), 32'h A5);

    // All five pending with ptr at 3
    for (int k = 0; k < N; k++) toggle(k, 8'(8'h10 + k));
    repeat (LAT - 1) cycle();
    for (int j = 0; j < 5; j++) begin
      cycle();
      chk("all5_gidx", 32'(gidx), seq_a[j]);
      chk("all5_data", 32'(din), 32'(8'h10 + seq_a[j]));
    end
    cycle();
    chk("all5_idle", 32'(write), 0);

    // Full stall on sender 1
    full = 1'b1;
    toggle(1, 8'h5C);
    repeat (4) begin
      cycle();
      chk("stall_write", 32'(write), 0);
      chk("stall_ack1", 32'(ack[1]), 1);
    end
    full = 1'b0;
    cycle();
    chk("unstall_write", 32'(write), 1);
    chk("unstall_gidx", 32'(gidx), 1);
    chk("unstall_data", 32'(din), 32'h5C);
    cycle();

    // Fairness between senders 0 and 4
    toggle(0, 8'h01);
    toggle(4, 8'h41);
    have_prev = 1'b0; prev = 0; w0 = 0; max_w = 0;
    for (int j = 0; j < 12; j++) begin
      cycle();
      if (write) begin
        if (have_prev) chk("fair_alternate", 32'(gidx != 3'(prev)), 1);
        prev = int'(gidx);
        have_prev = 1'b1;
        if (gidx == 3'd0) w0++;
        if (gidx == 3'd4) begin
          if (w0 > max_w) max_w = w0;
          w0 = 0;
        end
      end
      if (req[0] == m_ack[0]) toggle(0, 8'($urandom));
      if (req[4] == m_ack[4]) toggle(4, 8'($urandom));
    end
    chk("fair_max_wait", 32'(max_w <= 1), 1);
    repeat (6) cycle();

    // Request-to-write latency
    toggle(4, 8'hE4);
    lat = 0; seen = 1'b0;
    while (lat < 10 && !seen) begin
      cycle();
      lat++;
      if (write) seen = 1'b1;
    end
    chk("latency", lat, LAT);
    chk("latency_gidx", 32'(gidx), 4);
    cycle();

    // Reset asserted right after a grant
    toggle(3, 8'h33);
    repeat (LAT) cycle();
    chk("pre_rst_write", 32'(write), 1);
    reset = 1'b0;
    req = '0;
    model_reset();
    #1;
    chk("mid_rst_write", 32'(write), 0);
    chk("mid_rst_ack", 32'(ack), 0);
    chk("mid_rst_data", 32'(din), 0);
    chk("mid_rst_gidx", 32'(gidx), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) begin
      cycle();
      chk("post_rst_nowrite", 32'(write), 0);
    end

    // Pointer restarted at PTR_INIT
    for (int k = 0; k < N; k++) toggle(k, 8'(8'h20 + k));
    repeat (LAT - 1) cycle();
    for (int j = 0; j < 5; j++) begin
      cycle();
      chk("ptr_init_gidx", 32'(gidx), seq_b[j]);
    end

    // Randomized traffic with random backpressure
    for (int j = 0; j < 400; j++) begin
      full = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < N; k++) begin
        if (req[k] == m_ack[k] && $urandom_range(0, 2) == 0) toggle(k, 8'($urandom));
      end
      cycle();
    end
    full = 1'b0;
    repeat (10) cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
